load_use_scoreboard: RTL and testbench
======================================

Name: load_use_scoreboard

Overview:
- Decode-stage hazard scoreboard: the producer-side tracker that works alongside the operand forwarding logic.
- Records each in-flight register write at issue time, with the number of cycles until its result can be forwarded.
- Asserts a decode stall while a source operand's producer cannot yet be forwarded (loads before M2, multi-cycle multiplies).
- Sits beside the decoder; drives the DE/IF hold and the DE->EX bubble insert.

Parameters:
- LOAD_LAT, 2, cycles after issue before a load result is forwardable (load reaches M2).
- MUL_LAT, 3, cycles after issue before a multiply result is forwardable; legal range 1..3.
- CNT_W, 2, width of each per-register countdown; must hold max(LOAD_LAT, MUL_LAT).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- de_valid  input  1  valid instruction in DE.
- de_rs1  input  5  source register 1.
- de_rs1_used  input  1  instruction reads rs1.
- de_rs2  input  5  source register 2.
- de_rs2_used  input  1  instruction reads rs2.
- de_rd  input  5  destination register.
- de_wb_en  input  1  instruction writes rd.
- de_op_class  input  2  00 ALU/CSR, 01 load, 10 multiply, 11 treated as ALU.
- pipe_hold  input  1  backend freeze (dmem not ready); whole pipeline frozen.
- flush  input  1  branch/exception kill of the DE instruction this cycle.
- stall_de  output  1  hold IF/DE, insert bubble into EX.
- issue  output  1  DE instruction advances to EX this cycle.
- busy_mask  output  32  bit i = register i has a non-forwardable pending write.
- stall_count  output  32  saturating count of stall_de cycles.

Behaviour:
- State: cnt[1..31] (CNT_W bits each); register x0 is never tracked. stall_count is 32 bits.
- Reset (synchronous, rst=1 at an edge): all cnt clear to 0 and stall_count to 0, overriding every other input that cycle. After reset: busy_mask=0, stall_de=0, issue=de_valid&!flush&!pipe_hold.
- hit1 = de_rs1_used && de_rs1!=0 && cnt[de_rs1]!=0; hit2 is the same for rs2.
- stall_de = de_valid && (hit1 || hit2). Combinational from registered cnt and current inputs; no extra latency.
- issue = de_valid && !stall_de && !flush && !pipe_hold.
- Per-cycle update, when pipe_hold=0:
  - Every nonzero cnt decrements by 1.
  - Then, if issue && de_wb_en && de_rd!=0, cnt[de_rd] <= LAT, where LAT = LOAD_LAT (class 01), MUL_LAT (class 10), or 0 (otherwise).
  - The set takes priority over the decrement on the same register.
- When pipe_hold=1: cnt frozen, no issue, stall_count frozen.
- A newer writer to the same rd overwrites cnt[rd] (youngest writer wins). This matches the forwarding unit's nearest-stage priority.
- An ALU writer sets cnt=0: the dependent instruction issues the next cycle and takes its value from EX forwarding.
- Load timing: issue at cycle t gives cnt=2 at t+1 and 1 at t+2. A dependent instruction stalls at t+1 and t+2, then issues at t+3 with the load in M2.
- flush: suppresses issue (no cnt set); decrements continue; stall_de is still computed but is don't-care for the pipeline.
- stall_count: +1 on each cycle with stall_de && !flush && !pipe_hold; saturates at 0xFFFFFFFF with no wrap.
- busy_mask[i] = (cnt[i]!=0); busy_mask[0] = 0 always.
- rs1==rs2 both hitting counts as one stall cycle, not two.

Test Plan:
- Load x5 (class 01) issued, next instruction reads x5 as rs1 -> stall_de=1 for exactly 2 cycles, issue=1 on the 3rd; stall_count=2.
- ALU writes x7, next instruction reads x7 as rs2 -> stall_de=0, issue=1 immediately; busy_mask stays 0.
- Multiply writes x3 (MUL_LAT=3), dependent instruction follows, pipe_hold=1 for 2 cycles during the stall -> stall lasts 3 un-held cycles plus 2 held cycles; cnt frozen while held; stall_count=3.
- Load x9 then, next cycle, ALU writes x9; a third instruction reads x9 -> no stall (cnt[9] overwritten to 0).
- Instruction reading x0 with cnt state arbitrary, and load to rd=0 -> stall_de=0, busy_mask[0]=0.
- Load x4 issued, rst=1 the next cycle -> busy_mask=0 and stall_count=0 after the edge; dependent instruction on x4 issues without stalling.

Source files
------------

// File: rtl/load_use_scoreboard.sv
// Decode-stage load-use / multi-cycle hazard scoreboard.
// Each architectural register (x1..x31) owns a small countdown that holds the
// number of cycles remaining until its youngest in-flight write can be picked
// up by the forwarding network. A nonzero count on a source operand stalls DE.

// Per-register countdown. Set wins over decrement; a backend hold freezes it.
module lus_reg_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             set,
  input  logic [CNT_W-1:0] set_val,
  output logic [CNT_W-1:0] cnt
);

  // Youngest writer overwrites; otherwise count down toward forwardable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!hold) begin
      if (set)
        cnt <= set_val;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

module load_use_scoreboard #(
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_valid,
  input  logic [4:0]  de_rs1,
  input  logic        de_rs1_used,
  input  logic [4:0]  de_rs2,
  input  logic        de_rs2_used,
  input  logic [4:0]  de_rd,
  input  logic        de_wb_en,
  input  logic [1:0]  de_op_class,
  input  logic        pipe_hold,
  input  logic        flush,
  output logic        stall_de,
  output logic        issue,
  output logic [31:0] busy_mask,
  output logic [31:0] stall_count
);

  localparam int                NUM_REGS = 32;
  localparam logic [CNT_W-1:0]  LOAD_CNT = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0]  MUL_CNT  = CNT_W'(MUL_LAT);

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            set_vec;
  logic [CNT_W-1:0]               lat;
  logic                           hit1;
  logic                           hit2;
  logic                           wr_track;

  // x0 is hardwired zero and never has a pending producer.
  assign cnt[0] = '0;

  // Forwardability latency of the issuing instruction; ALU results (and the
  // reserved class 11) are forwardable from EX on the very next cycle.
  always_comb begin
    lat = '0;
    case (de_op_class)
      OP_LOAD: lat = LOAD_CNT;
      OP_MUL:  lat = MUL_CNT;
      OP_ALU:  lat = '0;
      default: lat = '0;
    endcase
  end

  // Operand hazards: only operands actually read, never x0. rs1==rs2 still
  // yields one stall cycle because the two hits are simply OR-ed.
  always_comb begin
    hit1 = de_rs1_used && (de_rs1 != 5'd0) && (cnt[de_rs1] != '0);
    hit2 = de_rs2_used && (de_rs2 != 5'd0) && (cnt[de_rs2] != '0);
  end

  assign stall_de = de_valid && (hit1 || hit2);
  assign issue    = de_valid && !stall_de && !flush && !pipe_hold;
  assign wr_track = issue && de_wb_en && (de_rd != 5'd0);

  // One-hot destination select for the counter that gets (re)loaded.
  always_comb begin
    set_vec = '0;
    for (int i = 1; i < NUM_REGS; i++)
      set_vec[i] = wr_track && (de_rd == 5'(i));
  end

  // Counter array for x1..x31.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    lus_reg_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .hold    (pipe_hold),
      .set     (set_vec[g]),
      .set_val (lat),
      .cnt     (cnt[g])
    );
  end

  // Busy view for the forwarding unit / debug: any nonzero countdown.
  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < NUM_REGS; i++)
      busy_mask[i] = (cnt[i] != '0);
  end

  // Performance counter of real stall cycles; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (stall_de && !flush && !pipe_hold && (stall_count != 32'hFFFF_FFFF))
      stall_count <= stall_count + 32'd1;
  end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench for load_use_scoreboard: a table of per-cycle vectors
// plus a hand-written mid-flight reset sequence; expectations flow through a
// queue and are compared against the DUT just after inputs settle.
module tb_load_use_scoreboard;

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wb;
    logic [1:0] op;
    logic       hold;
    logic       flush;
  } in_t;

  typedef struct {
    logic        stall;
    logic        issue;
    logic [31:0] busy;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_valid;
  logic [4:0]  de_rs1;
  logic        de_rs1_used;
  logic [4:0]  de_rs2;
  logic        de_rs2_used;
  logic [4:0]  de_rd;
  logic        de_wb_en;
  logic [1:0]  de_op_class;
  logic        pipe_hold;
  logic        flush;
  logic        stall_de;
  logic        issue;
  logic [31:0] busy_mask;
  logic [31:0] stall_count;

  int   checks = 0;
  int   errors = 0;
  int   row    = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  load_use_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .de_valid    (de_valid),
    .de_rs1      (de_rs1),
    .de_rs1_used (de_rs1_used),
    .de_rs2      (de_rs2),
    .de_rs2_used (de_rs2_used),
    .de_rd       (de_rd),
    .de_wb_en    (de_wb_en),
    .de_op_class (de_op_class),
    .pipe_hold   (pipe_hold),
    .flush       (flush),
    .stall_de    (stall_de),
    .issue       (issue),
    .busy_mask   (busy_mask),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m(int i);
    return 32'd1 << i;
  endfunction

  function automatic vec_t mk(bit r, bit v, int rs1, bit u1, int rs2, bit u2,
                              int rd, bit wb, int op, bit hold, bit fl,
                              bit es, bit ei, logic [31:0] eb, int ec);
    vec_t t;
    t.i.rst = r;   t.i.v = v;
    t.i.rs1 = 5'(rs1); t.i.u1 = u1;
    t.i.rs2 = 5'(rs2); t.i.u2 = u2;
    t.i.rd  = 5'(rd);  t.i.wb = wb;
    t.i.op  = 2'(op);  t.i.hold = hold; t.i.flush = fl;
    t.e.stall = es; t.e.issue = ei; t.e.busy = eb; t.e.cnt = 32'(ec);
    return t;
  endfunction

  //        v rs1 u1 rs2 u2 rd wb op hold fl  stall issue busy  count
  function automatic void add(bit v, int rs1, bit u1, int rs2, bit u2, int rd,
                              bit wb, int op, bit hold, bit fl, bit es, bit ei,
                              logic [31:0] eb, int ec);
    tbl.push_back(mk(1'b0, v, rs1, u1, rs2, u2, rd, wb, op, hold, fl, es, ei, eb, ec));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d %s got=%h want=%h", row, name, act, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL row%0d scoreboard empty got=%0d want=%0d", row, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk("stall_de",    {31'd0, stall_de}, {31'd0, e.stall});
    chk("issue",       {31'd0, issue},    {31'd0, e.issue});
    chk("busy_mask",   busy_mask,         e.busy);
    chk("stall_count", stall_count,       e.cnt);
  endtask

  // Drive one cycle's inputs away from the active edge, then check outputs.
  task automatic step(vec_t t);
    @(negedge clk);
    rst         = t.i.rst;
    de_valid    = t.i.v;
    de_rs1      = t.i.rs1;
    de_rs1_used = t.i.u1;
    de_rs2      = t.i.rs2;
    de_rs2_used = t.i.u2;
    de_rd       = t.i.rd;
    de_wb_en    = t.i.wb;
    de_op_class = t.i.op;
    pipe_hold   = t.i.hold;
    flush       = t.i.flush;
    exp_q.push_back(t.e);
    #2;
    compare();
    row++;
  endtask

  initial begin
    // Reset state and a plain ALU issue.
    add(0, 0,0, 0,0,  0,0,0, 0,0,  0,0, 0,      0);
    add(1, 0,0, 0,0,  1,1,0, 0,0,  0,1, 0,      0);
    // Load x5, dependent rs1 read: two stall cycles, issues on the third.
    add(1, 0,0, 0,0,  5,1,1, 0,0,  0,1, 0,      0);
    add(1, 5,1, 0,0,  6,1,0, 0,0,  1,0, m(5),   0);
    add(1, 5,1, 0,0,  6,1,0, 0,0,  1,0, m(5),   1);
    add(1, 5,1, 0,0,  6,1,0, 0,0,  0,1, 0,      2);
    // ALU x7 then rs2 read: no stall.
    add(1, 0,0, 0,0,  7,1,0, 0,0,  0,1, 0,      2);
    add(1, 0,0, 7,1,  8,1,0, 0,0,  0,1, 0,      2);
    // Multiply x3 with two held cycles in the middle of the stall.
    add(1, 0,0, 0,0,  3,1,2, 0,0,  0,1, 0,      2);
    add(1, 3,1, 0,0, 10,1,0, 0,0,  1,0, m(3),   2);
    add(1, 3,1, 0,0, 10,1,0, 1,0,  1,0, m(3),   3);
    add(1, 3,1, 0,0, 10,1,0, 1,0,  1,0, m(3),   3);
    add(1, 3,1, 0,0, 10,1,0, 0,0,  1,0, m(3),   3);
    add(1, 3,1, 0,0, 10,1,0, 0,0,  1,0, m(3),   4);
    add(1, 3,1, 0,0, 10,1,0, 0,0,  0,1, 0,      5);
    // Load x9 overwritten by ALU x9: reader does not stall.
    add(1, 0,0, 0,0,  9,1,1, 0,0,  0,1, 0,      5);
    add(1, 0,0, 0,0,  9,1,0, 0,0,  0,1, m(9),   5);
    add(1, 9,1, 0,0, 11,1,0, 0,0,  0,1, 0,      5);
    // x0: never tracked, never stalls, even with other registers busy.
    add(1, 0,0, 0,0, 12,1,1, 0,0,  0,1, 0,      5);
    add(1, 0,1, 0,1,  0,1,1, 0,0,  0,1, m(12),  5);
    add(1, 0,1, 0,1,  0,0,0, 0,0,  0,1, m(12),  5);
    add(0, 0,0, 0,0,  0,0,0, 0,0,  0,0, 0,      5);
    // Flush: no count, no set, decrement continues.
    add(1, 0,0, 0,0, 13,1,1, 0,0,  0,1, 0,      5);
    add(1,13,1, 0,0, 14,1,1, 0,1,  1,0, m(13),  5);
    add(1,13,1, 0,0, 14,1,1, 0,0,  1,0, m(13),  5);
    add(1,13,1, 0,0, 14,1,1, 0,0,  0,1, 0,      6);
    add(1, 0,0, 0,0, 15,1,1, 0,1,  0,0, m(14),  6);
    add(0, 0,0, 0,0,  0,0,0, 0,0,  0,0, m(14),  6);
    add(0, 0,0, 0,0,  0,0,0, 0,0,  0,0, 0,      6);
    // rs1 == rs2 both hitting counts once per cycle.
    add(1, 0,0, 0,0, 16,1,1, 0,0,  0,1, 0,      6);
    add(1,16,1,16,1,  0,0,0, 0,0,  1,0, m(16),  6);
    add(1,16,1,16,1,  0,0,0, 0,0,  1,0, m(16),  7);
    add(1,16,1,16,1,  0,0,0, 0,0,  0,1, 0,      8);
    // Unused operands ignored; class 11 behaves as ALU.
    add(1, 0,0, 0,0, 17,1,1, 0,0,  0,1, 0,      8);
    add(1,17,0,17,0,  0,0,0, 0,0,  0,1, m(17),  8);
    add(1, 0,0, 0,0, 18,1,3, 0,0,  0,1, m(17),  8);
    add(1, 0,0,18,1,  0,0,0, 0,0,  0,1, 0,      8);
    // de_valid=0 never stalls; hold freezes counters and blocks issue.
    add(1, 0,0, 0,0, 19,1,1, 0,0,  0,1, 0,      8);
    add(0,19,1, 0,0,  0,0,0, 0,0,  0,0, m(19),  8);
    add(1, 1,1, 0,0, 20,1,1, 1,0,  0,0, m(19),  8);
    add(0, 0,0, 0,0,  0,0,0, 0,0,  0,0, m(19),  8);
    add(0, 0,0, 0,0,  0,0,0, 0,0,  0,0, 0,      8);
    // rs2-only hazard.
    add(1, 0,0, 0,0, 22,1,1, 0,0,  0,1, 0,      8);
    add(1, 0,0,22,1,  0,0,0, 0,0,  1,0, m(22),  8);
    add(1, 0,0,22,1,  0,0,0, 0,0,  1,0, m(22),  9);
    add(1, 0,0,22,1,  0,0,0, 0,0,  0,1, 0,     10);

    rst = 1'b1; de_valid = 1'b0; de_rs1 = '0; de_rs1_used = 1'b0;
    de_rs2 = '0; de_rs2_used = 1'b0; de_rd = '0; de_wb_en = 1'b0;
    de_op_class = '0; pipe_hold = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[k]) step(tbl[k]);

    // Mid-flight reset: load x4 then rst; state and counter clear together.
    step(mk(0, 1, 0,0, 0,0,  4,1,1, 0,0,  0,1, 0,     10));
    step(mk(1, 1, 4,1, 0,0, 20,1,1, 0,0,  1,0, m(4),  10));
    step(mk(0, 1, 4,1, 0,0, 21,1,0, 0,0,  0,1, 0,      0));
    step(mk(0, 0, 0,0, 0,0,  0,0,0, 0,0,  0,0, 0,      0));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover expectations got=%0d want=%0d", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
